// File: rtl/mem_cycle_ctl.sv
// CPU-side initiator for the 32k x 12 core memory responder: issues a start,
// captures read data on strobe, supplies write-back data and waits for done.
module mem_cycle_ctl #(
  parameter int TIMEOUT = 200,
  parameter int AW      = 15,
  parameter int DW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rd_data,
  output logic          mem_start,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  input  logic          strobe_n,
  input  logic          mem_done_n
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_STROBE, WAIT_DONE, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic          seen_strobe;
  logic          timeout_hit;

  // timer counts edges since mem_start rose; the abort lands TIMEOUT edges later
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      seen_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_data     <= '0;
      mem_start   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          mem_addr    <= req_addr;
          wr_q        <= req_write;
          wdata_q     <= wr_data;
          busy        <= 1'b1;
          mem_start   <= 1'b1;
          timer       <= '0;
          err         <= 1'b0;
          seen_strobe <= 1'b0;
          state       <= ARM;
        end
        // mem_done_n is still low from the previous cycle until the responder restarts
        ARM: begin
          timer <= timer + 1'b1;
          if (timeout_hit) begin
            mem_start <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else if (mem_done_n) begin
            state <= WAIT_STROBE;
          end
        end
        WAIT_STROBE: begin
          timer <= timer + 1'b1;
          if (timeout_hit) begin
            mem_start <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else if (!strobe_n) begin
            // strobe wins over a coincident done; completion follows next edge
            rd_data     <= mem_data_out;
            mem_data_in <= wr_q ? wdata_q : mem_data_out;
            seen_strobe <= 1'b1;
            state       <= WAIT_DONE;
          end else if (!mem_done_n) begin
            mem_start <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (!mem_done_n) begin
            mem_start <= 1'b0;
            err       <= err | ~seen_strobe;
            done      <= 1'b1;
            state     <= DONE;
          end else if (timeout_hit) begin
            mem_start <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctl.sv
// Directed bench for mem_cycle_ctl against a behavioural core-memory responder
// with selectable fault modes (no done, no strobe, strobe coincident with done).
module tb_mem_cycle_ctl;

  localparam int M_NORMAL   = 0;
  localparam int M_NODONE   = 1;
  localparam int M_NOSTROBE = 2;
  localparam int M_SIMUL    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_write = 1'b0;
  logic [14:0] req_addr = '0;
  logic [11:0] wr_data = '0;
  logic        busy, done, err, mem_start;
  logic [11:0] rd_data, mem_data_in, mem_data_out;
  logic [14:0] mem_addr;
  logic        strobe_n = 1'b1;
  logic        mem_done_n = 1'b0;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  mem_cycle_ctl #(.TIMEOUT(200), .AW(15), .DW(12)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
    .req_addr(req_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .rd_data(rd_data), .mem_start(mem_start), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .strobe_n(strobe_n), .mem_done_n(mem_done_n)
  );

  // ---------------- responder model ----------------
  logic [11:0] mem [0:32767];
  logic        rsp_prev = 1'b0;
  logic [14:0] raddr = '0;
  int          rcnt = 0;
  int          mode = M_NORMAL;
  int          s_on;
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [11:0] pre_data = '0;

  always_comb begin
    s_on = 50;
    if (mode == M_NOSTROBE) s_on = 1000;
    else if (mode == M_SIMUL) s_on = 149;
  end

  assign mem_data_out = strobe_n ? 12'o0000 : mem[raddr];

  always @(posedge clk) begin
    rsp_prev <= mem_start;
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_start && !rsp_prev) begin
      raddr      <= mem_addr;
      rcnt       <= 1;
      mem_done_n <= 1'b1;
      strobe_n   <= 1'b1;
    end else if (rcnt > 0 && rcnt < 250) begin
      rcnt <= rcnt + 1;
      if (rcnt + 1 == s_on) strobe_n <= 1'b0;
      if (rcnt + 1 == s_on + 10) strobe_n <= 1'b1;
      if (rcnt + 1 == 149 && mode != M_NODONE) mem_done_n <= 1'b0;
      if (rcnt + 1 == 100 && (mode == M_NORMAL || mode == M_NODONE))
        mem[raddr] <= mem_data_in;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic preload(input logic [14:0] a, input logic [11:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one request; dk is the edge (after accept edge E0) after which done was seen.
  task automatic run_cycle(input logic wr, input logic [14:0] a, input logic [11:0] wd,
                           output int dk, output logic [11:0] mdi60,
                           output logic e0_ms, output logic e0_busy, output logic e0_err,
                           output logic ms_d, output logic busy_d, output logic err_d,
                           output logic done_n1, output logic busy_n1);
    @(negedge clk);
    req = 1'b1; req_write = wr; req_addr = a; wr_data = wd;
    @(posedge clk); #1;
    req = 1'b0;
    e0_ms = mem_start; e0_busy = busy; e0_err = err;
    dk = -1; mdi60 = '0; ms_d = 1'b1; busy_d = 1'b0; err_d = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == 60) mdi60 = mem_data_in;
      if (done) begin
        dk = k; ms_d = mem_start; busy_d = busy; err_d = err;
        break;
      end
    end
    @(posedge clk); #1;
    done_n1 = done; busy_n1 = busy;
  endtask

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [11:0] pre;
    logic [11:0] wdata;
    logic [11:0] exp_rd;
    logic [11:0] exp_mdi;
    logic [11:0] exp_mem;
  } vec_t;

  vec_t        vt [5];
  int          dk;
  logic [11:0] mdi60;
  logic        e0_ms, e0_busy, e0_err, ms_d, busy_d, err_d, done_n1, busy_n1;
  int          acc [3];
  int          dn [3];
  int          na, nd;
  logic        pms;

  initial begin
    vt[0] = '{1'b0, 15'o01234, 12'o4321, 12'o0000, 12'o4321, 12'o4321, 12'o4321};
    vt[1] = '{1'b1, 15'o70000, 12'o0000, 12'o7777, 12'o0000, 12'o7777, 12'o7777};
    vt[2] = '{1'b0, 15'o70000, 12'o7777, 12'o0000, 12'o7777, 12'o7777, 12'o7777};
    vt[3] = '{1'b1, 15'o00001, 12'o5555, 12'o1234, 12'o5555, 12'o1234, 12'o1234};
    vt[4] = '{1'b0, 15'o77777, 12'o0001, 12'o0000, 12'o0001, 12'o0001, 12'o0001};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst mem_start", mem_start, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_data_in", mem_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(15'o01234, 12'o4321);
    preload(15'o70000, 12'o0000);
    preload(15'o00001, 12'o5555);
    preload(15'o77777, 12'o0001);
    preload(15'o00002, 12'o6060);
    preload(15'o00003, 12'o2525);

    // table-driven normal reads/writes
    for (int i = 0; i < 5; i++) begin
      run_cycle(vt[i].wr, vt[i].addr, vt[i].wdata, dk, mdi60, e0_ms, e0_busy, e0_err,
                ms_d, busy_d, err_d, done_n1, busy_n1);
      chk($sformatf("v%0d accept mem_start", i), e0_ms, 1);
      chk($sformatf("v%0d accept busy", i), e0_busy, 1);
      chk($sformatf("v%0d done edge", i), dk, 150);
      chk($sformatf("v%0d busy at done", i), busy_d, 1);
      chk($sformatf("v%0d mem_start at done", i), ms_d, 0);
      chk($sformatf("v%0d err", i), err_d, 0);
      chk($sformatf("v%0d done pulse width", i), done_n1, 0);
      chk($sformatf("v%0d busy after", i), busy_n1, 0);
      chk($sformatf("v%0d rd_data", i), rd_data, vt[i].exp_rd);
      chk($sformatf("v%0d mem_data_in at E60", i), mdi60, vt[i].exp_mdi);
      chk($sformatf("v%0d mem_addr held", i), mem_addr, vt[i].addr);
      chk($sformatf("v%0d memory", i), mem[vt[i].addr], vt[i].exp_mem);
    end

    // strobe and done arrive together: capture first, complete one edge later
    mode = M_SIMUL;
    run_cycle(1'b0, 15'o00003, 12'o0000, dk, mdi60, e0_ms, e0_busy, e0_err,
              ms_d, busy_d, err_d, done_n1, busy_n1);
    chk("simul done edge", dk, 151);
    chk("simul err", err_d, 0);
    chk("simul rd_data", rd_data, 12'o2525);

    // done without strobe
    mode = M_NOSTROBE;
    run_cycle(1'b0, 15'o01234, 12'o0000, dk, mdi60, e0_ms, e0_busy, e0_err,
              ms_d, busy_d, err_d, done_n1, busy_n1);
    chk("nostrobe done edge", dk, 150);
    chk("nostrobe err", err_d, 1);
    chk("nostrobe mem_start", ms_d, 0);
    chk("nostrobe done pulse width", done_n1, 0);
    chk("nostrobe rd_data kept", rd_data, 12'o2525);

    // responder never completes
    mode = M_NODONE;
    run_cycle(1'b0, 15'o01234, 12'o0000, dk, mdi60, e0_ms, e0_busy, e0_err,
              ms_d, busy_d, err_d, done_n1, busy_n1);
    chk("timeout done edge", dk, 200);
    chk("timeout err", err_d, 1);
    chk("timeout mem_start", ms_d, 0);
    chk("timeout done pulse width", done_n1, 0);
    chk("timeout busy after", busy_n1, 0);
    chk("timeout err sticky", err, 1);

    // next request clears err
    mode = M_NORMAL;
    run_cycle(1'b0, 15'o70000, 12'o0000, dk, mdi60, e0_ms, e0_busy, e0_err,
              ms_d, busy_d, err_d, done_n1, busy_n1);
    chk("post-timeout err cleared", e0_err, 0);
    chk("post-timeout done edge", dk, 150);
    chk("post-timeout rd_data", rd_data, 12'o7777);

    // back-to-back: req held high through three reads
    acc = '{0, 0, 0}; dn = '{0, 0, 0}; na = 0; nd = 0; pms = mem_start;
    @(negedge clk);
    req = 1'b1; req_write = 1'b0; req_addr = 15'o01234;
    for (int k = 0; k < 700 && nd < 3; k++) begin
      @(posedge clk); #1;
      if (mem_start && !pms) begin
        if (na < 3) acc[na] = k;
        na++;
      end
      if (done) begin
        dn[nd] = k;
        nd++;
        if (nd == 3) req = 1'b0;
      end
      pms = mem_start;
    end
    req = 1'b0;
    chk("b2b dones seen", nd, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b%0d accept-to-done", i), dn[i] - acc[i], 150);
    for (int i = 0; i < 2; i++) chk($sformatf("b2b%0d start low gap", i), acc[i+1] - dn[i], 2);
    chk("b2b rd_data", rd_data, 12'o4321);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b no extra start", mem_start, 0);
    chk("b2b idle busy", busy, 0);

    // reset asserted mid-cycle at E60
    @(negedge clk);
    req = 1'b1; req_write = 1'b0; req_addr = 15'o00002;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst mem_start", mem_start, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    repeat (120) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(1'b0, 15'o01234, 12'o0000, dk, mdi60, e0_ms, e0_busy, e0_err,
              ms_d, busy_d, err_d, done_n1, busy_n1);
    chk("post-rst done edge", dk, 150);
    chk("post-rst err", err_d, 0);
    chk("post-rst rd_data", rd_data, 12'o4321);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
